// File: rtl/boss_ctrl.sv
// Boss controller for STAGE3: entry descent, edge-bouncing patrol, hurt/death handling
// and a 4-frame walk animation, all advanced by frame_tick.
module boss_ctrl #(
  parameter int X_MAX      = 310,
  parameter int X_START    = 155,
  parameter int Y_HOME     = 40,
  parameter int SPEED      = 2,
  parameter int HP_MAX     = 8,
  parameter int ANIM_DIV   = 8,
  parameter int HURT_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [8:0] boss_x,
  output logic [8:0] boss_y,
  output logic [3:0] boss_state,
  output logic [3:0] boss_hp,
  output logic       boss_dead,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTER  = 3'd1,
    PATROL = 3'd2,
    HURT   = 3'd3,
    DEAD   = 3'd4
  } fsm_e;

  localparam logic [3:0] STAGE3 = 4'd6;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int HW = (HURT_TICKS > 1) ? $clog2(HURT_TICKS) : 1;
  localparam logic [8:0]    X_MAX_V   = 9'(X_MAX);
  localparam logic [8:0]    X_START_V = 9'(X_START);
  localparam logic [8:0]    Y_HOME_V  = 9'(Y_HOME);
  localparam logic [9:0]    SPEED_W   = 10'(SPEED);
  localparam logic [8:0]    SPEED_V   = 9'(SPEED);
  localparam logic [3:0]    HP_MAX_V  = 4'(HP_MAX);
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [HW-1:0] HURT_LAST = HW'(HURT_TICKS - 1);

  fsm_e          fsm_q, fsm_d;
  logic [8:0]    x_q, x_d, y_q, y_d;
  logic [3:0]    bst_q, bst_d, hp_q, hp_d;
  logic          dead_q, dead_d, dir_q, dir_d;  // dir: 1 = moving right
  logic [AW-1:0] anim_q, anim_d;
  logic [HW-1:0] hurt_q, hurt_d;
  logic [9:0]    x_right;

  assign x_right = {1'b0, x_q} + SPEED_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      x_q    <= X_START_V;
      y_q    <= '0;
      bst_q  <= '0;
      hp_q   <= HP_MAX_V;
      dead_q <= 1'b0;
      dir_q  <= 1'b1;
      anim_q <= '0;
      hurt_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      x_q    <= x_d;
      y_q    <= y_d;
      bst_q  <= bst_d;
      hp_q   <= hp_d;
      dead_q <= dead_d;
      dir_q  <= dir_d;
      anim_q <= anim_d;
      hurt_q <= hurt_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    x_d    = x_q;
    y_d    = y_q;
    bst_d  = bst_q;
    hp_d   = hp_q;
    dead_d = dead_q;
    dir_d  = dir_q;
    anim_d = anim_q;
    hurt_d = hurt_q;
    if (state != STAGE3) begin
      // Leaving the stage wipes the boss back to its entry condition.
      fsm_d  = IDLE;
      x_d    = X_START_V;
      y_d    = '0;
      bst_d  = '0;
      hp_d   = HP_MAX_V;
      dead_d = 1'b0;
      dir_d  = 1'b1;
      anim_d = '0;
      hurt_d = '0;
    end else begin
      case (fsm_q)
        IDLE: fsm_d = ENTER;
        ENTER, PATROL: begin
          if (hit && hp_q != 4'd0) begin
            // A hit takes priority over movement in the same cycle.
            hp_d   = hp_q - 4'd1;
            hurt_d = '0;
            if (hp_q == 4'd1) begin
              fsm_d  = DEAD;
              dead_d = 1'b1;
              bst_d  = 4'd5;
            end else begin
              fsm_d = HURT;
              bst_d = 4'd4;
            end
          end else if (frame_tick) begin
            if (anim_q == ANIM_LAST) begin
              anim_d = '0;
              bst_d  = {2'b00, bst_q[1:0] + 2'd1};
            end else begin
              anim_d = anim_q + 1'b1;
            end
            if (fsm_q == ENTER) begin
              y_d = y_q + 9'd1;
              if (y_q + 9'd1 == Y_HOME_V) fsm_d = PATROL;
            end else if (dir_q) begin
              if (x_right >= {1'b0, X_MAX_V}) begin
                x_d   = X_MAX_V;
                dir_d = 1'b0;
              end else begin
                x_d = x_right[8:0];
              end
            end else begin
              if (x_q <= SPEED_V) begin
                x_d   = '0;
                dir_d = 1'b1;
              end else begin
                x_d = x_q - SPEED_V;
              end
            end
          end
        end
        HURT: begin
          if (frame_tick) begin
            if (hurt_q == HURT_LAST) begin
              hurt_d = '0;
              anim_d = '0;
              bst_d  = '0;
              fsm_d  = (y_q < Y_HOME_V) ? ENTER : PATROL;
            end else begin
              hurt_d = hurt_q + 1'b1;
            end
          end
        end
        DEAD: ;
        default: fsm_d = IDLE;
      endcase
    end
  end

  assign boss_x     = x_q;
  assign boss_y     = y_q;
  assign boss_state = bst_q;
  assign boss_hp    = hp_q;
  assign boss_dead  = dead_q;
  assign fsm_state  = fsm_q;

endmodule
